// File: rtl/loader_pkg.sv
// Shared state encoding and word geometry for the instruction loader.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
      DONE    = 3'd3,
      CHECK   = 3'd4
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_WIDTH     = 32;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 8-to-32 packer: three held bytes plus the byte on the bus form the word
// when the fourth byte of a group is accepted.
module byte_packer
   import loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [7:0]            byteIn,
   output logic [WORD_WIDTH-1:0] wordOut,
   output logic                  wordReady
);

   logic [WORD_WIDTH-9:0] shift;
   logic [1:0]            lane;

   // wordOut is only meaningful while wordReady is high
   assign wordReady = accept && (lane == 2'(BYTES_PER_WORD - 1));
   assign wordOut   = {shift, byteIn};

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shift <= '0;
         lane  <= '0;
      end else if (clear) begin
         shift <= '0;
         lane  <= '0;
      end else if (accept) begin
         shift <= {shift[WORD_WIDTH-17:0], byteIn};
         lane  <= lane + 2'd1;
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Streams bytes into 32-bit instruction-memory writes at BASE_ADDR, BASE_ADDR+4, ...
// Define LOADER_CHECKSUM_EN to append a 4-byte XOR checksum phase (CHECK state).
module instruction_loader
   import loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          MEM_WORDS   = 1024,
   parameter int          COUNT_WIDTH = 11
)(
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] wordCount,
   input  logic [7:0]             byteIn,
   input  logic                   byteValid,
   output logic                   byteReady,
   output logic                   memWrEn,
   output logic [31:0]            memAddr,
   output logic [31:0]            memData,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic                   checksumErr
);

   localparam logic [COUNT_WIDTH-1:0] MEM_LIMIT = COUNT_WIDTH'(MEM_WORDS);

   state_t                 state, state_next;
   logic [COUNT_WIDTH-1:0] limit, word_idx, idx_next;
   logic                   start_ok, accept, word_ready;
   logic [WORD_WIDTH-1:0]  packed_word;

   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign accept   = byteValid && byteReady;
   assign idx_next = word_idx + COUNT_WIDTH'(1);

   byte_packer u_packer (
      .clk       (clk),
      .resetN    (resetN),
      .clear     (start_ok),
      .accept    (accept),
      .byteIn    (byteIn),
      .wordOut   (packed_word),
      .wordReady (word_ready)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      byteReady  = 1'b0;
      memWrEn    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start_ok) state_next = (wordCount == '0) ? DONE : COLLECT;
         end
         COLLECT: begin
            byteReady = 1'b1;
            busy      = 1'b1;
            if (word_ready) state_next = WRITE;
         end
         WRITE: begin
            memWrEn = 1'b1;
            busy    = 1'b1;
            if (idx_next == limit) begin
`ifdef LOADER_CHECKSUM_EN
               state_next = CHECK;
`else
               state_next = DONE;
`endif
            end else begin
               state_next = COLLECT;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            byteReady = 1'b1;
            busy      = 1'b1;
            if (word_ready) state_next = DONE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // Write address/data are captured on the 4th byte so they only move entering WRITE
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         limit    <= '0;
         word_idx <= '0;
         overflow <= 1'b0;
         memAddr  <= '0;
         memData  <= '0;
      end else begin
         if (start_ok) begin
            limit    <= (wordCount > MEM_LIMIT) ? MEM_LIMIT : wordCount;
            overflow <= (wordCount > MEM_LIMIT);
            word_idx <= '0;
         end
         if ((state == COLLECT) && word_ready) begin
            memData <= packed_word;
            memAddr <= BASE_ADDR + (32'(word_idx) << 2);
         end
         if (state == WRITE) word_idx <= idx_next;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] xor_acc;
   logic        csum_err;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         xor_acc  <= '0;
         csum_err <= 1'b0;
      end else if (start_ok) begin
         xor_acc  <= '0;
         csum_err <= 1'b0;
      end else begin
         if (state == WRITE) xor_acc <= xor_acc ^ memData;
         if ((state == CHECK) && word_ready) csum_err <= (packed_word != xor_acc);
      end
   end

   assign checksumErr = csum_err;
`else
   assign checksumErr = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: idle, basic/stalled loads, limits, mid-load reset
// and, when LOADER_CHECKSUM_EN is defined, the checksum phase.
module tb_instruction_loader;

   logic        clk;
   logic        resetN;
   logic        start;
   logic [10:0] wordCount;
   logic [7:0]  byteIn;
   logic        byteValid;
   logic        byteReady;
   logic        memWrEn;
   logic [31:0] memAddr;
   logic [31:0] memData;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        checksumErr;

   int checks = 0;
   int errors = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_count = 0;
   int          run      = 0;
   int          max_run  = 0;
   int          rdy_bad  = 0;
   bit          watch_rdy = 1'b0;

   instruction_loader dut (
      .clk         (clk),
      .resetN      (resetN),
      .start       (start),
      .wordCount   (wordCount),
      .byteIn      (byteIn),
      .byteValid   (byteValid),
      .byteReady   (byteReady),
      .memWrEn     (memWrEn),
      .memAddr     (memAddr),
      .memData     (memData),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .checksumErr (checksumErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (memWrEn === 1'b1) begin
         wr_addr_q.push_back(memAddr);
         wr_data_q.push_back(memData);
         wr_count <= wr_count + 1;
         run      <= run + 1;
         if (run + 1 > max_run) max_run <= run + 1;
      end else begin
         run <= 0;
      end
      if (watch_rdy && (byteReady !== ~memWrEn)) rdy_bad <= rdy_bad + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_dut();
      resetN    = 1'b0;
      start     = 1'b0;
      byteValid = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
   endtask

   task automatic start_load(input int n);
      start     = 1'b1;
      wordCount = 11'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byteIn    = b;
      byteValid = 1'b1;
      while (byteReady !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("byte_accept_timeout", 32'(n), 32'd0);
      @(negedge clk);
      byteValid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic finish_load(input logic [31:0] csum);
`ifdef LOADER_CHECKSUM_EN
      send_word(csum);
`else
      if (csum === 32'hx) $display("unused checksum");
`endif
      wait_done();
   endtask

   initial begin
      int base;
      resetN    = 1'b0;
      start     = 1'b0;
      wordCount = '0;
      byteIn    = '0;
      byteValid = 1'b0;

      // Reset then idle
      repeat (2) @(negedge clk);
      check("rst_byteReady", {31'd0, byteReady}, 32'd0);
      check("rst_memWrEn", {31'd0, memWrEn}, 32'd0);
      check("rst_memAddr", memAddr, 32'd0);
      check("rst_memData", memData, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_checksumErr", {31'd0, checksumErr}, 32'd0);
      resetN = 1'b1;
      @(negedge clk);
      byteValid = 1'b1;
      byteIn    = 8'hFF;
      repeat (5) @(negedge clk);
      check("idle_no_write", 32'(wr_count), 32'd0);
      check("idle_byteReady", {31'd0, byteReady}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      byteValid = 1'b0;

      // Basic 2-word load, back-to-back bytes
      base = wr_count;
      start_load(2);
      check("basic_busy", {31'd0, busy}, 32'd1);
      send_word(32'h20080005);
      send_word(32'h8C090004);
      finish_load(32'hAC010001);
      check("basic_count", 32'(wr_count - base), 32'd2);
      check("basic_addr0", wr_addr_q[base], 32'h0);
      check("basic_data0", wr_data_q[base], 32'h20080005);
      check("basic_addr1", wr_addr_q[base+1], 32'h4);
      check("basic_data1", wr_data_q[base+1], 32'h8C090004);
      check("basic_pulse_width", 32'(max_run), 32'd1);
      check("basic_overflow", {31'd0, overflow}, 32'd0);
      check("basic_checksumErr", {31'd0, checksumErr}, 32'd0);
      repeat (3) @(negedge clk);
      check("basic_done_held", {31'd0, done}, 32'd1);
      check("basic_busy_low", {31'd0, busy}, 32'd0);
      check("basic_addr_held", memAddr, 32'h4);
      check("basic_data_held", memData, 32'h8C090004);

      // Stalled stream: 3 idle cycles between bytes
      base = wr_count;
      start_load(2);
      watch_rdy = 1'b1;
      begin
         logic [7:0] bytes [8];
         bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
         for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            if (i < 7) repeat (3) @(negedge clk);
         end
      end
      watch_rdy = 1'b0;
      finish_load(32'hAC010001);
      check("stall_count", 32'(wr_count - base), 32'd2);
      check("stall_addr0", wr_addr_q[base], 32'h0);
      check("stall_data0", wr_data_q[base], 32'h20080005);
      check("stall_addr1", wr_addr_q[base+1], 32'h4);
      check("stall_data1", wr_data_q[base+1], 32'h8C090004);
      check("stall_ready_only_write", 32'(rdy_bad), 32'd0);
      check("stall_pulse_width", 32'(max_run), 32'd1);

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum
      base = wr_count;
      start_load(2);
      send_word(32'h20080005);
      send_word(32'h8C090004);
      finish_load(32'h00010001);
      check("csum_bad_count", 32'(wr_count - base), 32'd2);
      check("csum_bad_err", {31'd0, checksumErr}, 32'd1);
`endif

      // wordCount = 0: done next cycle, no writes
      reset_dut();
      base = wr_count;
      start_load(0);
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("zero_no_write", 32'(wr_count - base), 32'd0);
      check("zero_overflow", {31'd0, overflow}, 32'd0);
      check("zero_checksumErr", {31'd0, checksumErr}, 32'd0);

      // wordCount = 1025: clipped to 1024 writes with overflow
      base = wr_count;
      start_load(1025);
      check("ovf_flag_early", {31'd0, overflow}, 32'd1);
      check("ovf_done_cleared", {31'd0, done}, 32'd0);
      for (int i = 0; i < 1024; i++) send_word({16'hC0DE, 16'(i)});
      finish_load(32'h0);
      repeat (5) @(negedge clk);
      check("ovf_count", 32'(wr_count - base), 32'd1024);
      check("ovf_first_addr", wr_addr_q[base], 32'h0);
      check("ovf_last_addr", wr_addr_q[base+1023], 32'hFFC);
      check("ovf_last_data", wr_data_q[base+1023], 32'hC0DE03FF);
      check("ovf_flag_held", {31'd0, overflow}, 32'd1);
      check("ovf_done", {31'd0, done}, 32'd1);
      check("ovf_pulse_width", 32'(max_run), 32'd1);

      // Reset mid-load discards the partial second word
      reset_dut();
      base = wr_count;
      start_load(3);
      send_word(32'h01020304);
      send_byte(8'h05);
      send_byte(8'h06);
      resetN = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_byteReady", {31'd0, byteReady}, 32'd0);
      check("midrst_memAddr", memAddr, 32'd0);
      check("midrst_memData", memData, 32'd0);
      check("midrst_overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      check("midrst_one_write", 32'(wr_count - base), 32'd1);
      check("midrst_wr_data", wr_data_q[base], 32'h01020304);
      @(negedge clk);
      resetN = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_no_more_writes", 32'(wr_count - base), 32'd1);
      check("midrst_done", {31'd0, done}, 32'd0);
      start_load(1);
      send_word(32'h11223344);
      finish_load(32'h11223344);
      check("reload_count", 32'(wr_count - base), 32'd2);
      check("reload_addr", wr_addr_q[base+1], 32'h0);
      check("reload_data", wr_data_q[base+1], 32'h11223344);
      check("reload_checksumErr", {31'd0, checksumErr}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
